// File: rtl/vga_pkg.sv
// vga_pkg: timing constants and pixel type shared with the VGA timing generator
package vga_pkg;
   localparam int HA_STA = 288;
   localparam int LINE = 1312;
   localparam int SCREEN = 800;
   localparam int VA_END = 768;
   localparam int CW = 4;
   typedef struct packed {
      logic [CW-1:0] r;
      logic [CW-1:0] g;
      logic [CW-1:0] b;
   } rgb_t;
endpackage

// File: rtl/vga_delay_line.sv
// vga_delay_line: enable-gated shift register carrying sync and window flags
module vga_delay_line #(
   parameter int W = 4,
   parameter int DEPTH = 2
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         en,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);
   logic [W-1:0] sr [DEPTH];
   // shift one place per enabled tick, cleared by reset
   always_ff @(posedge clk or negedge reset)
      if (!reset)
         for (int i = 0; i < DEPTH; i++) sr[i] <= '0;
      else if (en) begin
         sr[0] <= d;
         for (int i = 1; i < DEPTH; i++) sr[i] <= sr[i-1];
      end
   assign q = sr[DEPTH-1];
endmodule

// File: rtl/vga_pixel_fetch.sv
// vga_pixel_fetch: maps timing counters to image-window addresses and drives delay-matched RGB/syncs
module vga_pixel_fetch
   import vga_pkg::*;
#(
   parameter int HA_STA = vga_pkg::HA_STA,
   parameter int IMG_W = 256,
   parameter int IMG_H = 256,
   parameter int X_OFS = 0,
   parameter int Y_OFS = 0,
   parameter int SCALE_LOG2 = 0,
   parameter int RD_LAT = 1,
   parameter int CW = vga_pkg::CW,
   parameter logic [3*CW-1:0] BORDER = '0,
   localparam int AW = 1 + $clog2(IMG_W*IMG_H)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          pix_stb,
   input  logic          hsync_in,
   input  logic          vsync_in,
   input  logic          active_in,
   input  logic          screenend_in,
   input  logic [10:0]   x_in,
   input  logic [9:0]    y_in,
   input  logic          buf_sel,
   output logic [AW-1:0] mem_addr,
   output logic          mem_en,
   input  logic [3*CW-1:0] mem_data,
   output logic          hsync,
   output logic          vsync,
   output logic [CW-1:0] red,
   output logic [CW-1:0] green,
   output logic [CW-1:0] blue,
   output logic          frame_done
);
   localparam int RW = $clog2(IMG_H);
   localparam int CB = $clog2(IMG_W);
   localparam logic [11:0] X0 = 12'(HA_STA + X_OFS);
   localparam logic [11:0] Y0 = 12'(Y_OFS);
   localparam logic [11:0] WL = 12'(IMG_W << SCALE_LOG2);
   localparam logic [11:0] HL = 12'(IMG_H << SCALE_LOG2);
   logic [11:0] col, row;
   logic in_win, bank;
   logic [3:0] dl_q;
   // window coordinates; wrapped negative values fall outside the limits
   always_comb begin
      col = {1'b0, x_in} - X0;
      row = {2'b0, y_in} - Y0;
      in_win = active_in & ({1'b0, x_in} >= X0) & ({2'b0, y_in} >= Y0) & (col < WL) & (row < HL);
   end
   assign mem_en = pix_stb;
   vga_delay_line #(.W(4), .DEPTH(RD_LAT + 1)) u_dl (
      .clk(clk),
      .reset(reset),
      .en(pix_stb),
      .d({hsync_in, vsync_in, active_in, in_win}),
      .q(dl_q)
   );
   // address generation and bank latch at the frame boundary
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         mem_addr <= '0;
         bank <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         frame_done <= pix_stb & screenend_in;
         if (pix_stb) begin
            if (in_win) mem_addr <= {bank, row[RW-1+SCALE_LOG2 -: RW], col[CB-1+SCALE_LOG2 -: CB]};
            if (screenend_in) bank <= buf_sel;
         end
      end
   // output register: pixel data, border or black, aligned with the delayed syncs
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         {hsync, vsync} <= 2'b00;
         {red, green, blue} <= '0;
      end else if (pix_stb) begin
         {hsync, vsync} <= dl_q[3:2];
         {red, green, blue} <= dl_q[0] ? mem_data : dl_q[1] ? BORDER : '0;
      end
endmodule

// File: tb/tb_vga_pixel_fetch.sv
// tb_vga_pixel_fetch: directed vectors for two configurations plus sync, gap and bank sequences
module tb_vga_pixel_fetch;
   logic clk = 0, reset = 0, pix_stb = 0, hsync_in = 0, vsync_in = 0, active_in = 0;
   logic screenend_in = 0, buf_sel = 0;
   logic [10:0] x_in = 0;
   logic [9:0] y_in = 0;
   logic [16:0] addr0, addr1;
   logic en0, en1, hs0, vs0, hs1, vs1, fd0, fd1;
   logic [3:0] r0, g0, b0, r1, g1, b1;
   logic [11:0] md0 = 0, md1a = 0, md1b = 0;
   int checks = 0, errors = 0;
   logic hin [200];
   logic vin [200];

   always #5 clk = ~clk;

   vga_pixel_fetch u0 (
      .clk(clk), .reset(reset), .pix_stb(pix_stb), .hsync_in(hsync_in), .vsync_in(vsync_in),
      .active_in(active_in), .screenend_in(screenend_in), .x_in(x_in), .y_in(y_in),
      .buf_sel(buf_sel), .mem_addr(addr0), .mem_en(en0), .mem_data(md0), .hsync(hs0),
      .vsync(vs0), .red(r0), .green(g0), .blue(b0), .frame_done(fd0)
   );

   vga_pixel_fetch #(.SCALE_LOG2(1), .RD_LAT(2), .BORDER(12'h5A3)) u1 (
      .clk(clk), .reset(reset), .pix_stb(pix_stb), .hsync_in(hsync_in), .vsync_in(vsync_in),
      .active_in(active_in), .screenend_in(screenend_in), .x_in(x_in), .y_in(y_in),
      .buf_sel(buf_sel), .mem_addr(addr1), .mem_en(en1), .mem_data(md1b), .hsync(hs1),
      .vsync(vs1), .red(r1), .green(g1), .blue(b1), .frame_done(fd1)
   );

   function automatic logic [11:0] f(input logic [16:0] a);
      return (a == 17'd0) ? 12'hABC : (a[11:0] ^ a[16:5]);
   endfunction

   // BRAM models: one and two enabled ticks of read latency
   always @(posedge clk) begin
      if (en0) md0 <= f(addr0);
      if (en1) begin
         md1a <= f(addr1);
         md1b <= md1a;
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic strobe();
      pix_stb = 1;
      @(posedge clk);
      #1 pix_stb = 0;
   endtask

   task automatic idle_in();
      x_in = 0; y_in = 0; active_in = 0; hsync_in = 0; vsync_in = 0; screenend_in = 0;
   endtask

   typedef struct {
      logic [10:0] x;
      logic [9:0]  y;
      logic        act;
      logic [16:0] a0;
      logic [11:0] c0;
      logic [16:0] a1;
      logic [11:0] c1;
   } vec_t;
   vec_t tv [11];

   initial begin
      tv[0]  = '{11'd288, 10'd0,   1'b1, 17'h00000, 12'hABC, 17'h00000, 12'hABC};
      tv[1]  = '{11'd543, 10'd255, 1'b1, 17'h0FFFF, 12'h800, 17'h07F7F, 12'hC84};
      tv[2]  = '{11'd544, 10'd255, 1'b1, 17'h0FFFF, 12'h000, 17'h07F80, 12'hC7C};
      tv[3]  = '{11'd388, 10'd300, 1'b1, 17'h0FFFF, 12'h000, 17'h09632, 12'h283};
      tv[4]  = '{11'd100, 10'd10,  1'b0, 17'h0FFFF, 12'h000, 17'h09632, 12'h000};
      tv[5]  = '{11'd800, 10'd600, 1'b1, 17'h0FFFF, 12'h000, 17'h09632, 12'h5A3};
      tv[6]  = '{11'd289, 10'd1,   1'b1, 17'h00101, 12'h109, 17'h00000, 12'hABC};
      tv[7]  = '{11'd288, 10'd2,   1'b1, 17'h00200, 12'h210, 17'h00100, 12'h108};
      tv[8]  = '{11'd289, 10'd2,   1'b1, 17'h00201, 12'h211, 17'h00100, 12'h108};
      tv[9]  = '{11'd290, 10'd2,   1'b1, 17'h00202, 12'h212, 17'h00101, 12'h109};
      tv[10] = '{11'd291, 10'd2,   1'b1, 17'h00203, 12'h213, 17'h00101, 12'h109};
      for (int i = 0; i < 200; i++) begin
         hin[i] = (i >= 16 && i <= 111);
         vin[i] = (i >= 50 && i <= 60);
      end

      // reset held while inputs toggle
      for (int i = 0; i < 6; i++) begin
         x_in = 11'(288 + i); y_in = 10'(i); active_in = 1; hsync_in = i[0]; vsync_in = i[1];
         screenend_in = i[0]; buf_sel = 1;
         strobe();
      end
      chk("reset_addr", {15'd0, addr0}, 0);
      chk("reset_rgb", {20'd0, r0, g0, b0}, 0);
      chk("reset_sync", {30'd0, hs0, vs0}, 0);
      chk("reset_fd", {31'd0, fd0}, 0);
      chk("reset_rgb1", {20'd0, r1, g1, b1}, 0);
      idle_in(); buf_sel = 0;
      @(posedge clk); #1 reset = 1;

      // table-driven address and colour vectors
      foreach (tv[i]) begin
         x_in = tv[i].x; y_in = tv[i].y; active_in = tv[i].act;
         strobe();
         chk($sformatf("addr0_%0d", i), {15'd0, addr0}, {15'd0, tv[i].a0});
         chk($sformatf("addr1_%0d", i), {15'd0, addr1}, {15'd0, tv[i].a1});
         idle_in();
         strobe();
         strobe();
         chk($sformatf("rgb0_%0d", i), {20'd0, r0, g0, b0}, {20'd0, tv[i].c0});
         strobe();
         chk($sformatf("rgb1_%0d", i), {20'd0, r1, g1, b1}, {20'd0, tv[i].c1});
      end

      // sync delay with strobe gaps
      for (int i = 0; i < 4; i++) strobe();
      for (int j = 0; j < 200; j++) begin
         hsync_in = hin[j]; vsync_in = vin[j];
         strobe();
         chk($sformatf("hs0_%0d", j), {31'd0, hs0}, {31'd0, (j >= 2) ? hin[j-2] : 1'b0});
         chk($sformatf("vs0_%0d", j), {31'd0, vs0}, {31'd0, (j >= 2) ? vin[j-2] : 1'b0});
         chk($sformatf("hs1_%0d", j), {31'd0, hs1}, {31'd0, (j >= 3) ? hin[j-3] : 1'b0});
         if (j % 3 == 0) begin
            hsync_in = ~hsync_in;
            @(posedge clk); #1;
            chk($sformatf("hs0_gap_%0d", j), {31'd0, hs0}, {31'd0, (j >= 2) ? hin[j-2] : 1'b0});
            chk($sformatf("hs1_gap_%0d", j), {31'd0, hs1}, {31'd0, (j >= 3) ? hin[j-3] : 1'b0});
         end
      end
      idle_in();

      // bank switch requested mid-frame takes effect only at end of screen
      x_in = 288; y_in = 50; active_in = 1; buf_sel = 0;
      strobe();
      buf_sel = 1; y_in = 100;
      strobe();
      chk("bank_mid", {15'd0, addr0}, 32'h06400);
      chk("fd_mid", {31'd0, fd0}, 0);
      x_in = 289;
      strobe();
      chk("bank_mid2", {15'd0, addr0}, 32'h06401);
      idle_in(); screenend_in = 1;
      strobe();
      chk("fd_pulse", {31'd0, fd0}, 1);
      chk("fd_pulse1", {31'd0, fd1}, 1);
      screenend_in = 0;
      @(posedge clk); #1;
      chk("fd_clear", {31'd0, fd0}, 0);
      x_in = 288; y_in = 0; active_in = 1;
      strobe();
      chk("bank_new", {15'd0, addr0}, 32'h10000);
      chk("bank_new1", {15'd0, addr1}, 32'h10000);
      chk("fd_once", {31'd0, fd0}, 0);
      x_in = 290; hsync_in = 1;
      strobe();
      strobe();

      // reset mid-frame clears bank and pipeline
      #2 reset = 0;
      #1;
      chk("rst_addr", {15'd0, addr0}, 0);
      chk("rst_rgb", {20'd0, r0, g0, b0}, 0);
      chk("rst_hs", {31'd0, hs0}, 0);
      @(posedge clk); #1 reset = 1;
      x_in = 288; y_in = 1; active_in = 1; hsync_in = 0;
      strobe();
      chk("rst_bank", {15'd0, addr0}, 32'h00100);
      chk("rst_out_black", {20'd0, r0, g0, b0}, 0);
      chk("rst_out_hs", {31'd0, hs0}, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
